poker_card_loader: RTL and testbench
====================================

// Module: poker_card_loader
// PURPOSE
//  Upstream feeder and result capture for the combinational Poker IP. Accepts one card per
//  valid cycle on a narrow serial bus, assembles the packed public/hole card buses that drive
//  the Poker IP, registers its OUT_WINNER once loading completes, and presents it with a
//  one-cycle out_valid strobe. Sits between the card-stream source and the Poker IP instance.
// PARAMETERS
//  IP_WIDTH   9   number of players; total cards per deal NCARD = 5 + 2*IP_WIDTH (default 23)
// PORTS
//  clk                clk     input   1            rising-edge clock
//  rst_n              input   1            asynchronous active-low reset
//  in_valid           input   1            card on in_num/in_suit is valid this cycle
//  in_num             input   4            card rank, legal 1..13
//  in_suit            input   2            card suit 0..3
//  pub_num_o          output  20           to IN_PUB_CARD_NUM; pub card k at [4k+:4]
//  pub_suit_o         output  10           to IN_PUB_CARD_SUIT; pub card k at [2k+:2]
//  hole_num_o         output  8*IP_WIDTH   to IN_HOLE_CARD_NUM; player p card c at [8p+4c+:4]
//  hole_suit_o        output  4*IP_WIDTH   to IN_HOLE_CARD_SUIT; player p card c at [4p+2c+:2]
//  winner_i           input   IP_WIDTH     from OUT_WINNER (combinational from the *_o buses)
//  busy               output  1            high in LOAD/EVAL/OUT
//  out_valid          output  1            one-cycle strobe; out_winner valid only while high
//  out_winner         output  IP_WIDTH     registered winner vector (bit p = player p wins/ties)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, card counter=0, all *_o=0, out_valid=0,
//   out_winner=0, busy=0 (and out_err=0 when enabled). Mid-deal reset discards partial deal.
//  Card order: accepted cards 0..4 -> pub card 0..4; card 5+2p+c -> player p card c.
//  Only cycles with in_valid=1 count; gaps (in_valid=0) allowed anywhere inside a deal.
//  Counter: $clog2(NCARD+1) bits, increments per accepted card, returns to 0 after last card.
//  FSM:
//   IDLE: in_valid=1 -> store card 0, counter=1, go LOAD (busy=1 from next cycle).
//   LOAD: in_valid=1 -> store card at counter; if counter==NCARD-1 -> go EVAL, counter=0.
//   EVAL: one cycle; *_o stable; out_winner <= winner_i at the end of this cycle; go OUT.
//   OUT : out_valid=1 for exactly this cycle; go IDLE.
//  Latency: last card accepted at edge N -> EVAL during cycle N..N+1 -> out_valid high in
//   the cycle following edge N+2 (2 cycles after last card edge).
//  in_valid during EVAL/OUT: ignored, card dropped, no state change (source must not send).
//  *_o hold last deal's cards after OUT until overwritten by the next deal (not cleared).
//  out_winner holds its value after out_valid falls until the next EVAL; only reset clears it.
//  in_num outside 1..13 is stored unchanged; rank legality is not checked by this block.
//  Back-to-back deals: first card of next deal may arrive in the OUT cycle's successor (IDLE).
// CONFIGURATION
//  CARD_DUP_CHECK_EN defined:
//   - extra output out_err (1 bit); 52-bit seen mask indexed {in_suit,in_num-1}, cleared on
//     entry to IDLE; each accepted card sets its bit; if bit already set, sticky dup flag.
//   - out_err valid with out_valid (=dup flag); winner still captured normally; flag and mask
//     cleared on the next deal's first card. Ranks outside 1..13 also set the flag.
//  CARD_DUP_CHECK_EN undefined: no out_err port, no mask logic; behaviour otherwise identical.
// TESTING
//  1 Reset: assert rst_n=0 mid-LOAD after 7 cards -> all outputs 0, state IDLE; fresh 23-card
//    deal afterwards produces correct packing (stale cards not reused).
//  2 Packing: IP_WIDTH=9, stream cards n=1..13 cycling, suit=idx%4 -> pub_num_o[3:0]=1,
//    pub card 4 rank 5; player 8 card 1 (card 22) rank 10 at hole_num_o[71:68], suit 2 at [35:34].
//  3 Latency: 23 contiguous valid cycles, winner_i model returns 9'h004 -> out_valid exactly
//    one cycle, 2 cycles after last card edge, out_winner=9'h004; busy falls with OUT exit.
//  4 Bubbles: same deal with in_valid=0 inserted after cards 3, 10, 22 (3 cycles each) ->
//    identical *_o and out_winner to test 3; out_valid only after 23rd accepted card.
//  5 Ignored input: hold in_valid=1 through EVAL/OUT -> those cards dropped; next deal starts
//    only at IDLE; back-to-back deals both yield one out_valid each, correct winners.
//  6 CARD_DUP_CHECK_EN: deal with card (n=12,s=3) twice -> out_err=1 with out_valid; next
//    clean deal -> out_err=0; card n=0 or 14 -> out_err=1.

Source files
------------

// File: rtl/poker_card_loader.sv
// -----------------------------------------------------------------------------
// poker_card_loader
//
// Upstream feeder and result capture for the combinational Poker IP.
// Cards arrive one per valid cycle on a narrow bus. They are packed into the
// public/hole card buses that drive the Poker IP. Once a full deal is loaded,
// the IP's winner vector is registered and presented with a one-cycle
// out_valid strobe.
//
// Optional feature macro: CARD_DUP_CHECK_EN
//   When defined, this block adds an out_err output and a 52-bit seen-card mask.
//   out_err flags a card seen twice, or a rank outside 1..13, within a deal.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   card on in_num/in_suit is valid this cycle
//   in_num       in   card rank (legal 1..13, stored unchanged)
//   in_suit      in   card suit 0..3
//   pub_num_o    out  public card ranks,  card k at [4k+:4]
//   pub_suit_o   out  public card suits,  card k at [2k+:2]
//   hole_num_o   out  hole card ranks,    player p card c at [8p+4c+:4]
//   hole_suit_o  out  hole card suits,    player p card c at [4p+2c+:2]
//   winner_i     in   winner vector from the Poker IP (combinational from *_o)
//   busy         out  high while in LOAD/EVAL/OUT
//   out_valid    out  one-cycle strobe, out_winner valid while high
//   out_winner   out  registered winner vector (bit p = player p wins/ties)
//   out_err      out  (CARD_DUP_CHECK_EN only) duplicate/illegal card seen
//   dbg_state_o  out  current FSM state (0 IDLE, 1 LOAD, 2 EVAL, 3 OUT)
//
// Handshake: in_valid has no ready. A card is accepted on every rising edge
// where in_valid=1 and the FSM is in IDLE or LOAD. Cards presented during
// EVAL/OUT are dropped, so the source must not send them.
//
// Timing: the last card is accepted at edge N. EVAL occupies N..N+1 and
// out_winner is captured at N+1. OUT occupies N+1..N+2. out_valid is
// registered from the OUT state, so it is high for the one cycle after edge
// N+2, which is two cycles after the last card edge. busy falls at the same
// edge as OUT exits.
// -----------------------------------------------------------------------------
module poker_card_loader #(
  parameter int IP_WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [3:0]              in_num,
  input  logic [1:0]              in_suit,
  output logic [19:0]             pub_num_o,
  output logic [9:0]              pub_suit_o,
  output logic [8*IP_WIDTH-1:0]   hole_num_o,
  output logic [4*IP_WIDTH-1:0]   hole_suit_o,
  input  logic [IP_WIDTH-1:0]     winner_i,
  output logic                    busy,
  output logic                    out_valid,
  output logic [IP_WIDTH-1:0]     out_winner,
`ifdef CARD_DUP_CHECK_EN
  output logic                    out_err,
`endif
  output logic [1:0]              dbg_state_o
);

  localparam int NCARD = 5 + 2 * IP_WIDTH;
  localparam int CW    = $clog2(NCARD + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EVAL = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [19:0]             pub_num_q;
  logic [9:0]              pub_suit_q;
  logic [8*IP_WIDTH-1:0]   hole_num_q;
  logic [4*IP_WIDTH-1:0]   hole_suit_q;
  logic                    busy_q;
  logic                    out_valid_q;
  logic [IP_WIDTH-1:0]     out_winner_q;

  logic accept_d;
  assign accept_d = in_valid && ((state_q == S_IDLE) || (state_q == S_LOAD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pub_num_q    <= '0;
      pub_suit_q   <= '0;
      hole_num_q   <= '0;
      hole_suit_q  <= '0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_winner_q <= '0;
    end else begin
      // Strobe follows the OUT state by one register stage.
      out_valid_q <= (state_q == S_OUT);

      // Card slot is selected by the counter. It is 0 in IDLE, so the first
      // card of a deal always lands in public card 0.
      if (accept_d) begin
        for (int k = 0; k < 5; k++) begin
          if (cnt_q == CW'(k)) begin
            pub_num_q[4*k +: 4]  <= in_num;
            pub_suit_q[2*k +: 2] <= in_suit;
          end
        end
        // Hole card h = 2p+c lands at [4h+:4] / [2h+:2].
        for (int h = 0; h < 2 * IP_WIDTH; h++) begin
          if (cnt_q == CW'(h + 5)) begin
            hole_num_q[4*h +: 4]  <= in_num;
            hole_suit_q[2*h +: 2] <= in_suit;
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            cnt_q   <= CW'(1);
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (cnt_q == CW'(NCARD - 1)) begin
              cnt_q   <= '0;
              state_q <= S_EVAL;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        S_EVAL: begin
          // The card buses have been stable for this whole cycle.
          out_winner_q <= winner_i;
          state_q      <= S_OUT;
        end
        S_OUT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pub_num_o   = pub_num_q;
  assign pub_suit_o  = pub_suit_q;
  assign hole_num_o  = hole_num_q;
  assign hole_suit_o = hole_suit_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign out_winner  = out_winner_q;
  assign dbg_state_o = state_q;

`ifdef CARD_DUP_CHECK_EN
  // A legal card maps to the linear index suit*13 + (rank-1), in 0..51.
  // An illegal rank maps to no bit and raises the flag directly.
  logic        rank_ok_d;
  logic [5:0]  card_lin_d;
  logic [51:0] card_bit_d;
  logic [51:0] seen_q;
  logic        dup_q;
  logic        out_err_q;

  assign rank_ok_d  = (in_num != 4'd0) && (in_num <= 4'd13);
  assign card_lin_d = 6'(in_suit) * 6'd13 + 6'(in_num) - 6'd1;
  assign card_bit_d = rank_ok_d ? (52'd1 << card_lin_d) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q    <= '0;
      dup_q     <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      // Aligned with out_valid, which is also registered from OUT.
      out_err_q <= (state_q == S_OUT) && dup_q;
      if (state_q == S_OUT) begin
        seen_q <= '0;
      end else if (accept_d) begin
        if (state_q == S_IDLE) begin
          seen_q <= card_bit_d;
          dup_q  <= !rank_ok_d;
        end else begin
          seen_q <= seen_q | card_bit_d;
          if (!rank_ok_d || ((seen_q & card_bit_d) != '0)) dup_q <= 1'b1;
        end
      end
    end
  end

  assign out_err = out_err_q;
`endif

endmodule

// File: tb/tb_poker_card_loader.sv
module tb_poker_card_loader;

  localparam int IPW   = 9;
  localparam int NCARD = 5 + 2 * IPW;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUT
  logic              in_valid;
  logic [3:0]        in_num;
  logic [1:0]        in_suit;
  logic [19:0]       pub_num_o;
  logic [9:0]        pub_suit_o;
  logic [8*IPW-1:0]  hole_num_o;
  logic [4*IPW-1:0]  hole_suit_o;
  logic [IPW-1:0]    winner_i;
  logic              busy;
  logic              out_valid;
  logic [IPW-1:0]    out_winner;
  logic [1:0]        dbg_state_o;
`ifdef CARD_DUP_CHECK_EN
  logic              out_err;
`endif

  poker_card_loader #(.IP_WIDTH(IPW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_num      (in_num),
    .in_suit     (in_suit),
    .pub_num_o   (pub_num_o),
    .pub_suit_o  (pub_suit_o),
    .hole_num_o  (hole_num_o),
    .hole_suit_o (hole_suit_o),
    .winner_i    (winner_i),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_winner  (out_winner),
`ifdef CARD_DUP_CHECK_EN
    .out_err     (out_err),
`endif
    .dbg_state_o (dbg_state_o)
  );

  // ---------------------------------------------------------------- Poker IP stand-in
  // Returns the deal's winner only when the buses hold exactly the expected
  // deal, so a capture taken from a partial or mis-packed deal reads 9'h1FF.
  logic [19:0]      m_pub_num;
  logic [9:0]       m_pub_suit;
  logic [8*IPW-1:0] m_hole_num;
  logic [4*IPW-1:0] m_hole_suit;
  logic [IPW-1:0]   m_winner;

  assign winner_i = (pub_num_o == m_pub_num && pub_suit_o == m_pub_suit &&
                     hole_num_o == m_hole_num && hole_suit_o == m_hole_suit)
                    ? m_winner : 9'h1FF;

  // ---------------------------------------------------------------- scoreboard
  typedef struct packed {
    logic [IPW-1:0]   winner;
    logic [19:0]      pn;
    logic [9:0]       ps;
    logic [8*IPW-1:0] hn;
    logic [4*IPW-1:0] hs;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   last_card_cyc = -100;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected deal result per out_valid strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cyc == last_card_cyc + 1) begin
        check("busy_in_out", 128'(busy), 128'd1);
        check("valid_not_early", 128'(out_valid), 128'd0);
      end
      if (out_valid) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 128'd1, 128'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_winner", 128'(out_winner), 128'(e.winner));
          check("pub_num", 128'(pub_num_o), 128'(e.pn));
          check("pub_suit", 128'(pub_suit_o), 128'(e.ps));
          check("hole_num", 128'(hole_num_o), 128'(e.hn));
          check("hole_suit", 128'(hole_suit_o), 128'(e.hs));
          check("latency", 128'(cyc - last_card_cyc), 128'd2);
          check("busy_low_at_valid", 128'(busy), 128'd0);
`ifdef CARD_DUP_CHECK_EN
          check("out_err", 128'(out_err), 128'(e.err));
`endif
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  logic [3:0] d_num[NCARD];
  logic [1:0] d_suit[NCARD];

  // kind 0: rank (i%13)+1, suit i%4      kind 1: rank 13-(i%13), suit 3-(i%4)
  // kind 2: kind 0 with card 20 = (12,3), duplicating card 11
  // kind 3: kind 0 with card 3 rank 0    kind 4: kind 0 with card 7 rank 14
  task automatic fill(input int kind);
    for (int i = 0; i < NCARD; i++) begin
      if (kind == 1) begin
        d_num[i]  = 4'(13 - (i % 13));
        d_suit[i] = 2'(3 - (i % 4));
      end else begin
        d_num[i]  = 4'((i % 13) + 1);
        d_suit[i] = 2'(i % 4);
      end
    end
    if (kind == 2) begin d_num[20] = 4'd12; d_suit[20] = 2'd3; end
    if (kind == 3) d_num[3] = 4'd0;
    if (kind == 4) d_num[7] = 4'd14;
  endtask

  task automatic pack();
    for (int i = 0; i < 5; i++) begin
      m_pub_num[4*i +: 4]  = d_num[i];
      m_pub_suit[2*i +: 2] = d_suit[i];
    end
    for (int h = 0; h < 2 * IPW; h++) begin
      m_hole_num[4*h +: 4]  = d_num[h + 5];
      m_hole_suit[2*h +: 2] = d_suit[h + 5];
    end
  endtask

  task automatic send(input logic [3:0] n, input logic [1:0] s);
    @(negedge clk);
    in_valid = 1'b1;
    in_num   = n;
    in_suit  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_deal(input int kind, input logic [IPW-1:0] win,
                          input logic err, input logic gaps);
    exp_t e;
    fill(kind);
    pack();
    m_winner = win;
    e.winner = win;
    e.pn = m_pub_num;
    e.ps = m_pub_suit;
    e.hn = m_hole_num;
    e.hs = m_hole_suit;
    e.err = err;
    exp_q.push_back(e);
    for (int i = 0; i < NCARD; i++) begin
      send(d_num[i], d_suit[i]);
      if (i == NCARD - 1) last_card_cyc = cyc;
      if (gaps && (i == 3 || i == 10 || i == 22)) idle(3);
    end
  endtask

  task automatic wait_outs(input int target);
    int t = 0;
    while (n_out < target && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (n_out < target) check("timeout_out_valid", 128'(n_out), 128'(target));
  endtask

  // ---------------------------------------------------------------- test flow
  initial begin
    int outs = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_num   = '0;
    in_suit  = '0;
    m_pub_num = '0; m_pub_suit = '0; m_hole_num = '0; m_hole_suit = '0;
    m_winner = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_winner", 128'(out_winner), 128'd0);
    check("rst_pub_num", 128'(pub_num_o), 128'd0);
    check("rst_hole_num", 128'(hole_num_o), 128'd0);
    check("rst_state", 128'(dbg_state_o), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contiguous deal, latency and strobe width.
    run_deal(0, 9'h004, 1'b0, 1'b0);
    idle(1);
    outs++; wait_outs(outs);
    repeat (5) begin @(posedge clk); #1; end
    check("winner_hold", 128'(out_winner), 128'h004);
    check("valid_one_cycle", 128'(n_out), 128'(outs));
    check("idle_busy", 128'(busy), 128'd0);

    // Mid-deal reset after 7 cards.
    fill(1);
    for (int i = 0; i < 7; i++) send(d_num[i], d_suit[i]);
    check("load_busy", 128'(busy), 128'd1);
    check("load_state", 128'(dbg_state_o), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_winner", 128'(out_winner), 128'd0);
    check("mid_rst_pub_num", 128'(pub_num_o), 128'd0);
    check("mid_rst_hole_suit", 128'(hole_suit_o), 128'd0);
    check("mid_rst_state", 128'(dbg_state_o), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh deal after reset with hand-computed packing.
    run_deal(0, 9'h1A5, 1'b0, 1'b0);
    idle(1);
    outs++; wait_outs(outs);
    check("pk_pub_num", 128'(pub_num_o), 128'h54321);
    check("pk_pub_suit", 128'(pub_suit_o), 128'h0E4);
    check("pk_p8c1_num", 128'(hole_num_o[71:68]), 128'd10);
    check("pk_p8c1_suit", 128'(hole_suit_o[35:34]), 128'd2);
    check("pk_p0c0_num", 128'(hole_num_o[3:0]), 128'd6);
    check("pk_p0c0_suit", 128'(hole_suit_o[1:0]), 128'd1);

    // Bubbles inside the deal.
    run_deal(0, 9'h004, 1'b0, 1'b1);
    outs++; wait_outs(outs);

    // in_valid held through EVAL/OUT, then back-to-back deal.
    run_deal(1, 9'h0F0, 1'b0, 1'b0);
    send(4'd7, 2'd1);
    send(4'd7, 2'd1);
    run_deal(0, 9'h111, 1'b0, 1'b0);
    idle(1);
    outs += 2; wait_outs(outs);

`ifdef CARD_DUP_CHECK_EN
    run_deal(2, 9'h022, 1'b1, 1'b0);
    idle(1);
    outs++; wait_outs(outs);
    run_deal(0, 9'h033, 1'b0, 1'b0);
    idle(1);
    outs++; wait_outs(outs);
    run_deal(3, 9'h044, 1'b1, 1'b0);
    idle(1);
    outs++; wait_outs(outs);
    run_deal(4, 9'h055, 1'b1, 1'b0);
    idle(1);
    outs++; wait_outs(outs);
`endif

    idle(4);
    check("all_results_seen", 128'(exp_q.size()), 128'd0);
    check("out_count", 128'(n_out), 128'(outs));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_out=%0d", n_out);
    $fatal(1, "watchdog");
  end

endmodule
